// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational 4-bit ALU between two requesters.
// Operations are accepted over valid/ready, issued for one cycle, then returned tagged with the requester ID.
module alu_scheduler #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic [1:0]       REQ_VALID,
   output logic [1:0]       REQ_READY,
   input  logic [1:0]       REQ_CTRL0,
   input  logic [1:0]       REQ_CTRL1,
   input  logic [3:0]       REQ_A0,
   input  logic [3:0]       REQ_A1,
   input  logic [3:0]       REQ_B0,
   input  logic [3:0]       REQ_B1,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic             RSP_ID,
   output logic [3:0]       RSP_OUT,
   output logic             RSP_CF,
   output logic             RSP_Z,
   output logic [3:0]       ALU_IN1,
   output logic [3:0]       ALU_IN2,
   output logic [1:0]       ALU_CTRL,
   output logic             ALU_TOGGLE,
   input  logic [3:0]       ALU_OUT,
   input  logic             ALU_CF,
   input  logic             ALU_Z,
   output logic             BUSY,
   output logic [CNT_W-1:0] GNT_CNT0,
   output logic [CNT_W-1:0] GNT_CNT1
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic             id_q, id_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic [3:0]       a_q, a_d;
   logic [3:0]       b_q, b_d;
   logic [3:0]       out_q, out_d;
   logic             cf_q, cf_d;
   logic             z_q, z_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             busy_q, busy_d;
   logic             toggle_q, toggle_d;
   logic [1:0]       grant;

   // On a tie the requester that was not granted last time wins; no grant lock.
   always_comb begin
      grant = '0;
      if (state_q == ST_IDLE) begin
         case (REQ_VALID)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = '0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      ctrl_d  = ctrl_q;
      a_d     = a_q;
      b_d     = b_q;
      out_d   = out_q;
      cf_d    = cf_q;
      z_d     = z_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      case (state_q)
         ST_IDLE: begin
            if (grant[0] && REQ_VALID[0]) begin
               ctrl_d  = REQ_CTRL0;
               a_d     = REQ_A0;
               b_d     = REQ_B0;
               id_d    = 1'b0;
               last_d  = 1'b0;
               cnt0_d  = cnt0_q + 1'b1;
               state_d = ST_ISSUE;
            end else if (grant[1] && REQ_VALID[1]) begin
               ctrl_d  = REQ_CTRL1;
               a_d     = REQ_A1;
               b_d     = REQ_B1;
               id_d    = 1'b1;
               last_d  = 1'b1;
               cnt1_d  = cnt1_q + 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            out_d   = ALU_OUT;
            cf_d    = ALU_CF;
            z_d     = ALU_Z;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (RSP_READY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they align with state_q.
   always_comb begin
      rsp_valid_d = (state_d == ST_RESP);
      busy_d      = (state_d != ST_IDLE);
      toggle_d    = (state_d == ST_ISSUE);
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         id_q        <= 1'b0;
         ctrl_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         out_q       <= '0;
         cf_q        <= 1'b0;
         z_q         <= 1'b0;
         cnt0_q      <= '0;
         cnt1_q      <= '0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         toggle_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         ctrl_q      <= ctrl_d;
         a_q         <= a_d;
         b_q         <= b_d;
         out_q       <= out_d;
         cf_q        <= cf_d;
         z_q         <= z_d;
         cnt0_q      <= cnt0_d;
         cnt1_q      <= cnt1_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
         toggle_q    <= toggle_d;
      end
   end

   assign REQ_READY  = grant;
   assign RSP_VALID  = rsp_valid_q;
   assign RSP_ID     = id_q;
   assign RSP_OUT    = out_q;
   assign RSP_CF     = cf_q;
   assign RSP_Z      = z_q;
   assign ALU_IN1    = a_q;
   assign ALU_IN2    = b_q;
   assign ALU_CTRL   = ctrl_q;
   assign ALU_TOGGLE = toggle_q;
   assign BUSY       = busy_q;
   assign GNT_CNT0   = cnt0_q;
   assign GNT_CNT1   = cnt1_q;

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Round-robin scheduler that shares the team's single combinational 4-bit ALU (ADD/AND/NOT/ZERO, selected by a 2-bit CTRL and gated by TOGGLE) between two requesters. Each requester submits an operation over a valid/ready handshake. The block arbitrates between them, drives the ALU for exactly one cycle, and captures the result and flags. It then returns them on a single response channel, tagged with the requester ID. It sits between the requester logic and the ALU instance and is the only block allowed to drive the ALU inputs.

## Interface
- CNT_W, 8, width of the per-requester grant counters (wrap on overflow)

- CLK  in  1  rising-edge clock
- RESETN  in  1  asynchronous active-low reset
- REQ_VALID  in  2  bit i = requester i has an operation pending
- REQ_READY  out  2  bit i = operation from requester i accepted this cycle (at most one bit set)
- REQ_CTRL0 / REQ_CTRL1  in  2  ALU opcode: 00 ADD, 01 AND, 10 NOT, 11 ZERO
- REQ_A0 / REQ_A1  in  4  operand 1
- REQ_B0 / REQ_B1  in  4  operand 2 (ignored by NOT/ZERO)
- RSP_VALID  out  1  response available
- RSP_READY  in  1  consumer accepts response
- RSP_ID  out  1  requester that issued the operation
- RSP_OUT  out  4  captured ALU result
- RSP_CF  out  1  captured carry flag
- RSP_Z  out  1  captured zero flag
- ALU_IN1 / ALU_IN2  out  4  ALU operands
- ALU_CTRL  out  2  ALU opcode
- ALU_TOGGLE  out  1  ALU enable, high only in ISSUE
- ALU_OUT  in  4  ALU result
- ALU_CF  in  1  ALU carry flag
- ALU_Z  in  1  ALU zero flag
- BUSY  out  1  high whenever state is not IDLE
- GNT_CNT0 / GNT_CNT1  out  CNT_W  accepted-operation count per requester

## Operation
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. Reset state is IDLE.
- **IDLE, arbitration**
  - REQ_READY is combinational from REQ_VALID and the LAST register.
  - One valid requester: that requester wins.
  - Both valid: the requester != LAST wins.
  - None valid: REQ_READY = 00.
- **IDLE, accept.** When REQ_VALID[i] & REQ_READY[i] at a clock edge:
  - latch that requester's CTRL, A and B into operand registers;
  - ID <= i, LAST <= i;
  - GNT_CNTi <= GNT_CNTi + 1, mod 2^CNT_W;
  - go to ISSUE.
- **ISSUE (one cycle)**
  - ALU_IN1/ALU_IN2/ALU_CTRL come from the operand registers; ALU_TOGGLE = 1.
  - At the end-of-cycle edge, capture ALU_OUT/ALU_CF/ALU_Z into the response registers and go to RESP.
- **RESP**
  - RSP_VALID = 1. RSP_ID/OUT/CF/Z stay stable until RSP_READY.
  - On RSP_VALID & RSP_READY, go to IDLE.
  - REQ_READY = 00 in ISSUE and RESP; no new acceptance until back in IDLE.
- **ALU outputs outside ISSUE:** ALU_IN1/IN2/CTRL hold the operand registers, ALU_TOGGLE = 0, so the ALU holds its last value.
- **Reset values (asynchronous)**
  - state IDLE; LAST = 1, so requester 0 wins the first tie.
  - Operand, response and ID registers = 0; GNT_CNT0/1 = 0.
  - Outputs: RSP_VALID 0, REQ_READY 00, ALU_TOGGLE 0, BUSY 0.
- **Reset mid-operation:** the transaction is dropped and no response is produced. Requesters must re-submit.
- **Requester rules**
  - REQ_* must stay stable while REQ_VALID is high and unaccepted.
  - A requester may drop REQ_VALID before acceptance. Arbitration re-evaluates every IDLE cycle, with no grant lock.

## Timing
- Accept edge at cycle 0; ISSUE during cycle 1; RSP_VALID high from cycle 2.
- Minimum 3 cycles per operation (accept, issue, respond with RSP_READY already high). Peak throughput is 1 op / 3 cycles.
- RSP_READY low stalls in RESP indefinitely with outputs frozen. REQ_READY stays 00 meanwhile.
- RSP handshake in cycle n → IDLE in cycle n+1 → next acceptance possible at the end of cycle n+1.
- Both requesters continuously valid → grants alternate 0,1,0,1…; neither waits more than one operation.

## Test plan
- After reset, only REQ_VALID=01, CTRL0=00, A0=9, B0=8, RSP_READY=1 → REQ_READY=01 in cycle 0, ALU_TOGGLE=1 in cycle 1, then in cycle 2 RSP_VALID=1, RSP_ID=0, RSP_OUT=1, RSP_CF=1, RSP_Z=0; GNT_CNT0=1.
- Both requesters held valid: req0 = AND(A=0xC, B=0xA), req1 = NOT(A=0xF), 6 operations → RSP_ID sequence 0,1,0,1,0,1 with RSP_OUT 0x8,0x0 alternating, RSP_Z 0,1 alternating; GNT_CNT0=3, GNT_CNT1=3.
- ZERO op from requester 1, RSP_READY held low for 5 cycles → RSP_VALID stays 1 with RSP_OUT=0, RSP_Z=1, RSP_CF=0 stable; REQ_READY=00 and BUSY=1 throughout; response completes on the first RSP_READY cycle.
- RESETN pulsed low during ISSUE → immediately RSP_VALID=0, BUSY=0, ALU_TOGGLE=0, GNT counts 0; no response ever appears for the dropped operation.
- 256 accepted ops from requester 0 with CNT_W=8 → GNT_CNT0 wraps to 0; arbitration unaffected.
- REQ_VALID=10 raised, then dropped for one IDLE cycle while req0 rises → req0 granted (LAST=1 tie rule not needed); no spurious REQ_READY[1].
